strobe_log_arbiter: RTL and testbench

//  Shares one log output channel among NCH strobe-monitor channels.

---
 rtl/strobe_log_arbiter_pkg.sv | 19 +
 rtl/strobe_log_arbiter_rr_pick.sv | 31 +++
 rtl/strobe_log_arbiter.sv | 149 ++++++++++++++
 tb/tb_strobe_log_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/strobe_log_arbiter_pkg.sv
// Shared definitions for the strobe log arbiter: default widths, the
// channel-index width helper and the output register state encoding.
package strobe_log_arbiter_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_DW  = 8;
    localparam int DEF_TSW = 16;

    // Channel index width; at least one bit so a two-channel build still has a select.
    function automatic int chw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_HOLD = 1'b1
    } out_state_e;

endpackage

// File: rtl/strobe_log_arbiter_rr_pick.sv
// strobe_rr_pick: combinational round-robin pick. Scans the full-slot vector
// starting at the pointer and returns the first full index plus an any flag.
module strobe_rr_pick
    import strobe_log_arbiter_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    localparam int CHW = chw(NCH)
) (
    input  logic [NCH-1:0] full,
    input  logic [CHW-1:0] ptr,
    output logic [CHW-1:0] grant,
    output logic           any
);

    // First full slot at or after the pointer, wrapping modulo NCH.
    always_comb begin
        logic [CHW-1:0] idx;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CHW'((int'(ptr) + k) % NCH);
            if (!any && full[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/strobe_log_arbiter.sv
// strobe_log_arbiter: NCH one-entry capture slots drained round-robin into a
// single valid/ready log port, with sticky per-channel overflow flags.
// Optional capture timestamps are enabled by defining STROBE_LOG_TS_EN.
module strobe_log_arbiter
    import strobe_log_arbiter_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int DW  = DEF_DW,
`ifdef STROBE_LOG_TS_EN
    parameter int TSW = DEF_TSW,
`endif
    localparam int CHW = chw(NCH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] data,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [CHW-1:0]    log_chan,
    output logic [DW-1:0]     log_data,
`ifdef STROBE_LOG_TS_EN
    output logic [TSW-1:0]    log_ts,
`endif
    output logic [NCH-1:0]    ovf,
    input  logic              clr_ovf
);

    out_state_e        state_q, state_d;
    logic [NCH-1:0]    full_q, full_d;
    logic [DW-1:0]     slot_data_q [NCH];
    logic [DW-1:0]     slot_data_d [NCH];
    logic [CHW-1:0]    chan_q, chan_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [CHW-1:0]    ptr_q, ptr_d;
    logic [NCH-1:0]    ovf_q, ovf_d;
`ifdef STROBE_LOG_TS_EN
    logic [TSW-1:0]    ts_cnt_q, ts_cnt_d;
    logic [TSW-1:0]    slot_ts_q [NCH];
    logic [TSW-1:0]    slot_ts_d [NCH];
    logic [TSW-1:0]    out_ts_q, out_ts_d;
`endif

    logic [CHW-1:0]    grant;
    logic              any;
    logic              load;
    logic              grant_fire;

    strobe_rr_pick #(.NCH(NCH)) u_pick (
        .full  (full_q),
        .ptr   (ptr_q),
        .grant (grant),
        .any   (any)
    );

    // Output register may take a new record when empty or when the sink takes the current one.
    assign load       = (state_q == OUT_IDLE) || log_ready;
    assign grant_fire = load && any;

    // Next-state for slots, output register, pointer, overflow flags and timestamp counter.
    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        slot_data_d = slot_data_q;
        chan_d      = chan_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        ovf_d       = clr_ovf ? '0 : ovf_q;
`ifdef STROBE_LOG_TS_EN
        ts_cnt_d    = ts_cnt_q + TSW'(1);
        slot_ts_d   = slot_ts_q;
        out_ts_d    = out_ts_q;
`endif

        if (load) begin
            state_d = any ? OUT_HOLD : OUT_IDLE;
        end

        if (grant_fire) begin
            chan_d     = grant;
            out_data_d = slot_data_q[grant];
            full_d[grant] = 1'b0;
            ptr_d      = (grant == CHW'(NCH - 1)) ? '0 : grant + CHW'(1);
`ifdef STROBE_LOG_TS_EN
            out_ts_d   = slot_ts_q[grant];
`endif
        end

        // A slot being drained this cycle is free again, so a same-cycle request refills it.
        for (int i = 0; i < NCH; i++) begin
            if (req[i]) begin
                if (!full_d[i]) begin
                    full_d[i]      = 1'b1;
                    slot_data_d[i] = data[i*DW +: DW];
`ifdef STROBE_LOG_TS_EN
                    slot_ts_d[i]   = ts_cnt_q;
`endif
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers; reset clears everything, including slot payloads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
            state_q    <= OUT_IDLE;
            full_q     <= '0;
            chan_q     <= '0;
            out_data_q <= '0;
            ptr_q      <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_data_q[i] <= '0;
            end
`ifdef STROBE_LOG_TS_EN
            ts_cnt_q   <= '0;
            out_ts_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_ts_q[i] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            slot_data_q <= slot_data_d;
            chan_q      <= chan_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
`ifdef STROBE_LOG_TS_EN
            ts_cnt_q    <= ts_cnt_d;
            slot_ts_q   <= slot_ts_d;
            out_ts_q    <= out_ts_d;
`endif
        end
    end

    assign log_valid = (state_q == OUT_HOLD);
    assign log_chan  = chan_q;
    assign log_data  = out_data_q;
    assign ovf       = ovf_q;
`ifdef STROBE_LOG_TS_EN
    assign log_ts    = out_ts_q;
`endif

endmodule

// File: tb/tb_strobe_log_arbiter.sv
// Directed self-checking bench for strobe_log_arbiter (NCH=4, DW=8).
// The timestamp wrap case runs only when STROBE_LOG_TS_EN is defined (TSW=4).
module tb_strobe_log_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] data;
    logic              log_valid;
    logic              log_ready;
    logic [1:0]        log_chan;
    logic [DW-1:0]     log_data;
    logic [NCH-1:0]    ovf;
    logic              clr_ovf;
`ifdef STROBE_LOG_TS_EN
    logic [3:0]        log_ts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

`ifdef STROBE_LOG_TS_EN
    strobe_log_arbiter #(.NCH(NCH), .DW(DW), .TSW(4)) dut (
`else
    strobe_log_arbiter #(.NCH(NCH), .DW(DW)) dut (
`endif
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_chan  (log_chan),
        .log_data  (log_data),
`ifdef STROBE_LOG_TS_EN
        .log_ts    (log_ts),
`endif
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1ns so inputs change and outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        data      = '0;
        log_ready = 1'b1;
        clr_ovf   = 1'b0;
        #12;
        check("rst_valid", 32'(log_valid), 32'h0);
        check("rst_chan",  32'(log_chan),  32'h0);
        check("rst_data",  32'(log_data),  32'h0);
        check("rst_ovf",   32'(ovf),       32'h0);
        do_reset();

        // 1. single request, two-edge latency
        req = 4'b0001; data = 32'h0000_00A5;
        tick();
        req = '0;
        check("t1_valid_e1", 32'(log_valid), 32'h0);
        tick();
        check("t1_valid_e2", 32'(log_valid), 32'h1);
        check("t1_chan",     32'(log_chan),  32'h0);
        check("t1_data",     32'(log_data),  32'hA5);
        tick();
        check("t1_drained",  32'(log_valid), 32'h0);

        // 2. fairness from pointer 0
        do_reset();
        req = 4'b1111; data = 32'h4433_2211;
        tick();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t2_valid%0d", i), 32'(log_valid), 32'h1);
            check($sformatf("t2_chan%0d", i),  32'(log_chan),  32'(i));
            check($sformatf("t2_data%0d", i),  32'(log_data),  32'(8'h11 * (i + 1)));
        end
        tick();
        check("t2_idle", 32'(log_valid), 32'h0);

        // 3. backpressure and overflow on channel 0
        log_ready = 1'b0;
        req = 4'b0001; data = 32'h0000_0011;
        tick();
        data = 32'h0000_0022;
        tick();
        check("t3_hold11",   32'(log_data), 32'h11);
        check("t3_noovf",    32'(ovf),      32'h0);
        data = 32'h0000_0033;
        tick();
        req = '0;
        check("t3_ovf",      32'(ovf),      32'h1);
        check("t3_still11",  32'(log_data), 32'h11);
        tick();
        check("t3_stable",   32'(log_data), 32'h11);
        check("t3_stable_v", 32'(log_valid), 32'h1);
        log_ready = 1'b1;
        tick();
        check("t3_rec22",    32'(log_data), 32'h22);
        check("t3_rec22_ch", 32'(log_chan), 32'h0);
        tick();
        check("t3_idle",     32'(log_valid), 32'h0);
        check("t3_sticky",   32'(ovf),      32'h1);

        // 4. refill in the grant cycle on channel 1
        req = 4'b0010; data = 32'h0000_5500;
        tick();
        data = 32'h0000_6600;
        tick();
        req = '0;
        check("t4_rec55",    32'(log_data), 32'h55);
        check("t4_ch1a",     32'(log_chan), 32'h1);
        check("t4_noovf",    32'(ovf),      32'h1);
        tick();
        check("t4_rec66",    32'(log_data), 32'h66);
        check("t4_ch1b",     32'(log_chan), 32'h1);
        tick();
        check("t4_idle",     32'(log_valid), 32'h0);

        // 5. clear, set-wins-over-clear, reset mid-hold
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t5_clr",      32'(ovf), 32'h0);
        log_ready = 1'b0;
        req = 4'b0100; data = 32'h0077_0000;
        tick();
        data = 32'h0078_0000;
        tick();
        data = 32'h0079_0000; clr_ovf = 1'b1;
        tick();
        req = '0; clr_ovf = 1'b0;
        check("t5_setwins",  32'(ovf),      32'h4);
        check("t5_hold77",   32'(log_data), 32'h77);
        check("t5_hold_v",   32'(log_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("t5_rst_v",    32'(log_valid), 32'h0);
        check("t5_rst_ovf",  32'(ovf),       32'h0);
        check("t5_rst_data", 32'(log_data),  32'h0);
        tick();
        reset = 1'b0;
        log_ready = 1'b1;
        tick();
        tick();
        check("t5_empty",    32'(log_valid), 32'h0);

`ifdef STROBE_LOG_TS_EN
        // 6. timestamp wrap: capture at count 15 then count 0
        do_reset();
        repeat (15) tick();
        req = 4'b0001; data = 32'h0000_0001;
        tick();
        req = 4'b0010; data = 32'h0000_0200;
        tick();
        req = '0;
        check("t6_ts_f",  32'(log_ts),   32'hF);
        check("t6_ch0",   32'(log_chan), 32'h0);
        tick();
        check("t6_ts_0",  32'(log_ts),   32'h0);
        check("t6_ch1",   32'(log_chan), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
